startup_seq: RTL and testbench
==============================

# startup_seq

Synthesizable global-startup sequencer for the SoC top level. Drives global set/reset (GSR), global tristate (GTS), preload (PRLD) and global restore (GRESTORE) in the order the fabric requires. It gates the core reset on a filtered PLL lock and re-sequences on lock loss. It also services a level-request / pulse-acknowledge restore handshake from the debug/power controller.

## Interface

Parameters:
- LOCK_FILTER, 8: consecutive synchronized-lock cycles required before startup proceeds
- GTS_CYCLES, 4: cycles GTS is held after lock qualifies
- GSR_CYCLES, 16: cycles GSR/PRLD are held after GTS release
- RES_CYCLES, 8: GRESTORE pulse width in cycles
- CNT_W, 16: shared down/up counter width; every cycle parameter must satisfy 1 ≤ value < 2^CNT_W

Ports:
- clk  in  1  single system clock
- rst_n  in  1  asynchronous, active-low reset
- pll_locked_i  in  1  asynchronous PLL lock; synchronized internally by two flops reset to 0
- restore_req_i  in  1  level restore request
- restore_ack_o  out  1  one-cycle acknowledge at end of restore
- gts_o  out  1  global tristate, active high
- gsr_o  out  1  global set/reset, active high
- prld_o  out  1  preload, active high, tracks gsr_o
- grestore_o  out  1  global restore pulse, active high
- core_rst_n_o  out  1  core reset, active low
- ready_o  out  1  sequence complete and idle
- lock_lost_o  out  1  sticky flag, set on any lock loss after first qualification
- state_o  out  3  current state encoding

## Operation

- Reset values: gts_o=1, gsr_o=1, prld_o=1, grestore_o=0, core_rst_n_o=0, ready_o=0, restore_ack_o=0, lock_lost_o=0, state_o=0 (WAIT_LOCK), counter=0, sync flops=0.
- All outputs registered. States and encodings: WAIT_LOCK=0, GTS_HOLD=1, GSR_HOLD=2, RELEASE=3, RUN=4, RESTORE=5. Encodings 6–7 are unreachable and recover to WAIT_LOCK.
- WAIT_LOCK: the counter increments on each cycle with lock_s=1 and clears on lock_s=0. When the count reaches LOCK_FILTER, go to GTS_HOLD and clear the counter.
- GTS_HOLD: count GTS_CYCLES cycles, then clear gts_o and go to GSR_HOLD.
- GSR_HOLD: count GSR_CYCLES cycles, then clear gsr_o and prld_o and go to RELEASE.
- RELEASE: one cycle. Set core_rst_n_o=1 and ready_o=1, then go to RUN.
- RUN: if restore_req_i=1 and the request is armed, go to RESTORE, set grestore_o=1, clear ready_o, and load the counter.
- Arming: the request is armed at reset. It is disarmed by restore_ack_o and re-armed only after restore_req_i is sampled 0. A held request therefore never triggers twice.
- RESTORE: after RES_CYCLES cycles, clear grestore_o, pulse restore_ack_o for 1 cycle, set ready_o=1, return to RUN. core_rst_n_o stays 1 throughout.
- Lock loss: lock_s=0 in any state other than WAIT_LOCK has the following effect on the next edge:
  - go to WAIT_LOCK and clear the counter;
  - gts_o=gsr_o=prld_o=1, core_rst_n_o=0, ready_o=0, grestore_o=0;
  - no ack is issued;
  - lock_lost_o=1 and stays 1 until rst_n.
- Simultaneous events: lock loss beats restore request and counter expiry. restore_req_i outside RUN is ignored and not queued.
- Asynchronous reset mid-sequence (including mid-RESTORE) returns immediately to the reset values.

## Timing

- Edge 1 is the first rising clk edge with rst_n high. pll_locked_i is high throughout.
- lock_s=1 after edge 2. WAIT_LOCK exits at edge 2+LOCK_FILTER.
- gts_o falls after edge 2+LOCK_FILTER+GTS_CYCLES. With defaults this is edge 14.
- gsr_o and prld_o fall after edge 2+LOCK_FILTER+GTS_CYCLES+GSR_CYCLES. With defaults this is edge 30.
- core_rst_n_o and ready_o rise one edge later. With defaults this is edge 31.
- Restore: with restore_req_i sampled 1 at edge N in RUN:
  - grestore_o is 1 after edges N through N+RES_CYCLES-1;
  - grestore_o falls after edge N+RES_CYCLES;
  - restore_ack_o=1 and ready_o=1 after edge N+RES_CYCLES;
  - restore_ack_o returns to 0 after edge N+RES_CYCLES+1.
- Lock-loss response latency from a pll_locked_i fall: 3 edges, made up of 2 synchronizer edges plus 1 state edge.

## Test plan

- Cold start, defaults, lock high → gts_o falls after edge 14, gsr_o/prld_o after edge 30, core_rst_n_o/ready_o rise after edge 31, state_o=4.
- Lock glitch: lock high 5 cycles, low 1 cycle, then high → counter restarts; gts_o falls 8+4 edges after lock_s re-rises.
- Restore with req held high 20 cycles in RUN → grestore_o high exactly 8 cycles, one 1-cycle restore_ack_o, no second restore until req drops and rises again.
- Lock loss during RESTORE → grestore_o=0, gsr_o=gts_o=1, core_rst_n_o=0, no ack, lock_lost_o=1, state_o=0; then re-sequences with identical intervals.
- rst_n asserted mid-GSR_HOLD → all outputs return to reset values asynchronously; lock_lost_o=0.
- restore_req_i=1 during GSR_HOLD → ignored; ready_o still rises at edge 31; a restore starts only on a later armed request.

Source files
------------

// File: rtl/startup_seq.sv
// ---------------------------------------------------------------------------
// startup_seq
//
// Global-startup sequencer for the SoC top level. After the PLL lock has been
// stable for LOCK_FILTER synchronized cycles it releases GTS, then GSR/PRLD,
// and then the core reset. While running it serves a level-request /
// pulse-acknowledge GRESTORE handshake. Loss of lock at any point after
// qualification drops everything back to the power-on state and re-sequences.
//
// Ports
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   pll_locked_i   in   asynchronous PLL lock (two-flop synchronized)
//   restore_req_i  in   level restore request
//   restore_ack_o  out  one-cycle acknowledge at the end of a restore
//   gts_o          out  global tristate, active high
//   gsr_o          out  global set/reset, active high
//   prld_o         out  preload, active high, tracks gsr_o
//   grestore_o     out  global restore pulse, active high
//   core_rst_n_o   out  core reset, active low
//   ready_o        out  sequence complete and idle
//   lock_lost_o    out  sticky lock-loss flag, cleared only by rst_n
//   state_o        out  current state encoding
// ---------------------------------------------------------------------------
module startup_seq #(
  parameter int unsigned LOCK_FILTER = 8,
  parameter int unsigned GTS_CYCLES  = 4,
  parameter int unsigned GSR_CYCLES  = 16,
  parameter int unsigned RES_CYCLES  = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked_i,
  input  logic       restore_req_i,
  output logic       restore_ack_o,
  output logic       gts_o,
  output logic       gsr_o,
  output logic       prld_o,
  output logic       grestore_o,
  output logic       core_rst_n_o,
  output logic       ready_o,
  output logic       lock_lost_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    GTS_HOLD  = 3'd1,
    GSR_HOLD  = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    RESTORE   = 3'd5
  } state_t;

  // Terminal counts: the counter starts at 0 on entry, so the last counted
  // cycle of an N-cycle phase sees the value N-1.
  localparam logic [CNT_W-1:0] LF_LAST  = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] GTS_LAST = CNT_W'(GTS_CYCLES - 1);
  localparam logic [CNT_W-1:0] GSR_LAST = CNT_W'(GSR_CYCLES - 1);
  localparam logic [CNT_W-1:0] RES_LAST = CNT_W'(RES_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_armed;
  logic             r_gts;
  logic             r_gsr;
  logic             r_grestore;
  logic             r_core_rst_n;
  logic             r_ready;
  logic             r_ack;
  logic             r_lost;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_armed_nxt;
  logic             w_gts_nxt;
  logic             w_gsr_nxt;
  logic             w_grestore_nxt;
  logic             w_core_rst_n_nxt;
  logic             w_ready_nxt;
  logic             w_ack_nxt;
  logic             w_lost_nxt;
  logic             w_lock_s;

  assign w_lock_s = r_sync2;

  // Lock synchronizer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pll_locked_i;
      r_sync2 <= r_sync1;
    end
  end

  // State, counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= WAIT_LOCK;
      r_cnt        <= CNT_ZERO;
      r_armed      <= 1'b1;
      r_gts        <= 1'b1;
      r_gsr        <= 1'b1;
      r_grestore   <= 1'b0;
      r_core_rst_n <= 1'b0;
      r_ready      <= 1'b0;
      r_ack        <= 1'b0;
      r_lost       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_armed      <= w_armed_nxt;
      r_gts        <= w_gts_nxt;
      r_gsr        <= w_gsr_nxt;
      r_grestore   <= w_grestore_nxt;
      r_core_rst_n <= w_core_rst_n_nxt;
      r_ready      <= w_ready_nxt;
      r_ack        <= w_ack_nxt;
      r_lost       <= w_lost_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_gts_nxt        = r_gts;
    w_gsr_nxt        = r_gsr;
    w_grestore_nxt   = r_grestore;
    w_core_rst_n_nxt = r_core_rst_n;
    w_ready_nxt      = r_ready;
    w_ack_nxt        = 1'b0;
    w_lost_nxt       = r_lost;

    case (r_state)
      WAIT_LOCK: begin
        if (w_lock_s) begin
          if (r_cnt == LF_LAST) begin
            w_state_nxt = GTS_HOLD;
            w_cnt_nxt   = CNT_ZERO;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end else begin
          w_cnt_nxt = CNT_ZERO;
        end
      end

      GTS_HOLD: begin
        if (r_cnt == GTS_LAST) begin
          w_gts_nxt   = 1'b0;
          w_state_nxt = GSR_HOLD;
          w_cnt_nxt   = CNT_ZERO;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end

      GSR_HOLD: begin
        if (r_cnt == GSR_LAST) begin
          w_gsr_nxt   = 1'b0;
          w_state_nxt = RELEASE;
          w_cnt_nxt   = CNT_ZERO;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end

      RELEASE: begin
        w_core_rst_n_nxt = 1'b1;
        w_ready_nxt      = 1'b1;
        w_state_nxt      = RUN;
        w_cnt_nxt        = CNT_ZERO;
      end

      RUN: begin
        if (restore_req_i && r_armed) begin
          w_state_nxt    = RESTORE;
          w_grestore_nxt = 1'b1;
          w_ready_nxt    = 1'b0;
          w_cnt_nxt      = CNT_ZERO;
        end
      end

      RESTORE: begin
        if (r_cnt == RES_LAST) begin
          w_grestore_nxt = 1'b0;
          w_ack_nxt      = 1'b1;
          w_ready_nxt    = 1'b1;
          w_state_nxt    = RUN;
          w_cnt_nxt      = CNT_ZERO;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end

      default: begin
        // Unreachable encodings fall back to the power-on condition.
        w_state_nxt      = WAIT_LOCK;
        w_cnt_nxt        = CNT_ZERO;
        w_gts_nxt        = 1'b1;
        w_gsr_nxt        = 1'b1;
        w_grestore_nxt   = 1'b0;
        w_core_rst_n_nxt = 1'b0;
        w_ready_nxt      = 1'b0;
      end
    endcase

    // Lock loss overrides everything above, including restore completion,
    // so an interrupted restore never produces an acknowledge.
    if (!w_lock_s && (r_state != WAIT_LOCK)) begin
      w_state_nxt      = WAIT_LOCK;
      w_cnt_nxt        = CNT_ZERO;
      w_gts_nxt        = 1'b1;
      w_gsr_nxt        = 1'b1;
      w_grestore_nxt   = 1'b0;
      w_core_rst_n_nxt = 1'b0;
      w_ready_nxt      = 1'b0;
      w_ack_nxt        = 1'b0;
      w_lost_nxt       = 1'b1;
    end
  end

  // Arming: an issued acknowledge disarms; a sampled low request re-arms.
  // A request held across the acknowledge therefore cannot retrigger.
  always_comb begin
    w_armed_nxt = r_armed;
    if (w_ack_nxt) begin
      w_armed_nxt = 1'b0;
    end else if (!restore_req_i) begin
      w_armed_nxt = 1'b1;
    end
  end

  assign restore_ack_o = r_ack;
  assign gts_o         = r_gts;
  assign gsr_o         = r_gsr;
  assign prld_o        = r_gsr;
  assign grestore_o    = r_grestore;
  assign core_rst_n_o  = r_core_rst_n;
  assign ready_o       = r_ready;
  assign lock_lost_o   = r_lost;
  assign state_o       = r_state;

endmodule

// File: tb/tb_startup_seq.sv
// ---------------------------------------------------------------------------
// tb_startup_seq
//
// Testbench for startup_seq. Directed scenarios followed by a randomized
// phase. Expected outputs come from a reference model that tracks how many
// consecutive synchronized-lock edges have elapsed since the last reset or
// lock loss and derives every output from that count arithmetically, plus a
// remaining-cycles count for an active restore.
// ---------------------------------------------------------------------------
module tb_startup_seq;

  localparam int L = 8;
  localparam int G = 4;
  localparam int S = 16;
  localparam int R = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       pll   = 1'b0;
  logic       req   = 1'b0;
  logic       restore_ack_o;
  logic       gts_o;
  logic       gsr_o;
  logic       prld_o;
  logic       grestore_o;
  logic       core_rst_n_o;
  logic       ready_o;
  logic       lock_lost_o;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  startup_seq #(
    .LOCK_FILTER(L),
    .GTS_CYCLES (G),
    .GSR_CYCLES (S),
    .RES_CYCLES (R),
    .CNT_W      (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_locked_i (pll),
    .restore_req_i(req),
    .restore_ack_o(restore_ack_o),
    .gts_o        (gts_o),
    .gsr_o        (gsr_o),
    .prld_o       (prld_o),
    .grestore_o   (grestore_o),
    .core_rst_n_o (core_rst_n_o),
    .ready_o      (ready_o),
    .lock_lost_o  (lock_lost_o),
    .state_o      (state_o)
  );

  int testsRun  = 0;
  int failCount = 0;
  int edgeNum   = 0;

  // Reference model state.
  int mRun;
  int mRem;
  bit mArmed;
  bit mLost;
  bit mAck;
  bit d1;
  bit d2;

  task automatic modelReset();
    mRun   = 0;
    mRem   = 0;
    mArmed = 1'b1;
    mLost  = 1'b0;
    mAck   = 1'b0;
    d1     = 1'b0;
    d2     = 1'b0;
  endtask

  // One rising edge with the given sampled inputs.
  task automatic modelEdge(input bit pllV, input bit reqV);
    bit lockS;
    bit inRun;
    bit ackNow;
    lockS  = d2;
    d2     = d1;
    d1     = pllV;
    inRun  = (mRun > L + G + S);
    ackNow = 1'b0;
    if (!lockS) begin
      if (mRun >= L) mLost = 1'b1;
      mRun = 0;
      mRem = 0;
    end else begin
      mRun = mRun + 1;
      if (inRun) begin
        if (mRem > 0) begin
          mRem = mRem - 1;
          if (mRem == 0) ackNow = 1'b1;
        end else if (reqV && mArmed) begin
          mRem = R;
        end
      end
    end
    if (ackNow) mArmed = 1'b0;
    else if (!reqV) mArmed = 1'b1;
    mAck = ackNow;
  endtask

  function automatic logic [2:0] expState();
    if (mRun < L) return 3'd0;
    else if (mRun < L + G) return 3'd1;
    else if (mRun < L + G + S) return 3'd2;
    else if (mRun == L + G + S) return 3'd3;
    else if (mRem > 0) return 3'd5;
    else return 3'd4;
  endfunction

  task automatic checkSig(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s (edge %0d): observed %0d, expected %0d", tag, edgeNum, obs, exp);
    end
  endtask

  task automatic checkInt(input string tag, input int obs, input int exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s (edge %0d): observed %0d, expected %0d", tag, edgeNum, obs, exp);
    end
  endtask

  task automatic checkOutput();
    bit eCore;
    eCore = (mRun > L + G + S);
    checkSig("state",    state_o,                    expState());
    checkSig("gts",      {2'b00, gts_o},             {2'b00, mRun < L + G});
    checkSig("gsr",      {2'b00, gsr_o},             {2'b00, mRun < L + G + S});
    checkSig("prld",     {2'b00, prld_o},            {2'b00, mRun < L + G + S});
    checkSig("core_rst", {2'b00, core_rst_n_o},      {2'b00, eCore});
    checkSig("ready",    {2'b00, ready_o},           {2'b00, eCore && (mRem == 0)});
    checkSig("grestore", {2'b00, grestore_o},        {2'b00, mRem > 0});
    checkSig("ack",      {2'b00, restore_ack_o},     {2'b00, mAck});
    checkSig("lost",     {2'b00, lock_lost_o},       {2'b00, mLost});
  endtask

  // Called at a falling edge; drives inputs, advances n rising edges and
  // checks every output at the following falling edge.
  task automatic applyStimulus(input bit pllV, input bit reqV, input int n);
    repeat (n) begin
      pll = pllV;
      req = reqV;
      @(posedge clk);
      edgeNum++;
      modelEdge(pllV, reqV);
      @(negedge clk);
      checkOutput();
    end
  endtask

  // Called at a falling edge (or time 0); asserts reset between clock edges
  // so the outputs must change without a clock.
  task automatic doReset(input int holdCycles);
    #2 rst_n = 1'b0;
    #1 modelReset();
    checkSig("rst gts",      {2'b00, gts_o},         3'd1);
    checkSig("rst gsr",      {2'b00, gsr_o},         3'd1);
    checkSig("rst prld",     {2'b00, prld_o},        3'd1);
    checkSig("rst grestore", {2'b00, grestore_o},    3'd0);
    checkSig("rst core_rst", {2'b00, core_rst_n_o},  3'd0);
    checkSig("rst ready",    {2'b00, ready_o},       3'd0);
    checkSig("rst ack",      {2'b00, restore_ack_o}, 3'd0);
    checkSig("rst lost",     {2'b00, lock_lost_o},   3'd0);
    checkSig("rst state",    state_o,                3'd0);
    repeat (holdCycles) begin
      @(negedge clk);
      checkOutput();
    end
    rst_n   = 1'b1;
    edgeNum = 0;
  endtask

  initial begin
    int gCnt;
    int aCnt;
    int cnt;
    bit pllV;
    bit reqV;
    int lowLeft;

    // Cold start with lock high throughout.
    pll = 1'b1;
    req = 1'b0;
    doReset(2);
    applyStimulus(1, 0, 13);
    checkSig("cold gts@13", {2'b00, gts_o}, 3'd1);
    applyStimulus(1, 0, 1);
    checkSig("cold gts@14", {2'b00, gts_o}, 3'd0);
    applyStimulus(1, 0, 15);
    checkSig("cold gsr@29", {2'b00, gsr_o}, 3'd1);
    applyStimulus(1, 0, 1);
    checkSig("cold gsr@30",  {2'b00, gsr_o},        3'd0);
    checkSig("cold prld@30", {2'b00, prld_o},       3'd0);
    checkSig("cold core@30", {2'b00, core_rst_n_o}, 3'd0);
    applyStimulus(1, 0, 1);
    checkSig("cold core@31",  {2'b00, core_rst_n_o}, 3'd1);
    checkSig("cold ready@31", {2'b00, ready_o},      3'd1);
    checkSig("cold state@31", state_o,               3'd4);

    // Restore request held for 20 cycles, then a fresh request.
    gCnt = 0;
    aCnt = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 1, 1);
      gCnt += int'(grestore_o);
      aCnt += int'(restore_ack_o);
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 1);
      gCnt += int'(grestore_o);
      aCnt += int'(restore_ack_o);
    end
    checkInt("held req grestore cycles", gCnt, 8);
    checkInt("held req ack pulses", aCnt, 1);
    gCnt = 0;
    aCnt = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, 1, 1);
      gCnt += int'(grestore_o);
      aCnt += int'(restore_ack_o);
    end
    checkInt("rearmed grestore cycles", gCnt, 8);
    checkInt("rearmed ack pulses", aCnt, 1);
    applyStimulus(1, 0, 3);

    // Lock loss in the middle of a restore.
    applyStimulus(1, 1, 1);
    checkSig("restore started", state_o, 3'd5);
    applyStimulus(1, 0, 2);
    aCnt = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1);
      aCnt += int'(restore_ack_o);
    end
    checkInt("lockloss no ack", aCnt, 0);
    checkSig("lockloss state",    state_o,               3'd0);
    checkSig("lockloss lost",     {2'b00, lock_lost_o},  3'd1);
    checkSig("lockloss grestore", {2'b00, grestore_o},   3'd0);
    checkSig("lockloss gts",      {2'b00, gts_o},        3'd1);
    checkSig("lockloss gsr",      {2'b00, gsr_o},        3'd1);
    checkSig("lockloss core",     {2'b00, core_rst_n_o}, 3'd0);
    applyStimulus(0, 0, 3);
    cnt = 0;
    do begin
      applyStimulus(1, 0, 1);
      cnt++;
    end while (gts_o !== 1'b0 && cnt < 100);
    checkInt("relock gts interval", cnt, 14);

    // Asynchronous reset in the middle of GSR_HOLD clears the sticky flag.
    applyStimulus(1, 0, 5);
    checkSig("mid gsr state", state_o, 3'd2);
    checkSig("mid gsr lost", {2'b00, lock_lost_o}, 3'd1);
    doReset(2);

    // Lock glitch while still waiting for qualification.
    applyStimulus(1, 0, 5);
    applyStimulus(0, 0, 1);
    cnt = 0;
    do begin
      applyStimulus(1, 0, 1);
      cnt++;
    end while (gts_o !== 1'b0 && cnt < 100);
    checkInt("glitch gts interval", cnt, 14);
    checkSig("glitch lost", {2'b00, lock_lost_o}, 3'd0);
    cnt = 0;
    do begin
      applyStimulus(1, 0, 1);
      cnt++;
    end while (gsr_o !== 1'b0 && cnt < 100);
    checkInt("glitch gsr interval", cnt, 16);
    applyStimulus(1, 0, 1);
    checkSig("glitch ready", {2'b00, ready_o}, 3'd1);

    // Restore request during GSR_HOLD is ignored.
    doReset(1);
    applyStimulus(1, 0, 16);
    applyStimulus(1, 1, 10);
    applyStimulus(1, 0, 4);
    checkSig("early req ready@30", {2'b00, ready_o}, 3'd0);
    applyStimulus(1, 0, 1);
    checkSig("early req ready@31",    {2'b00, ready_o},    3'd1);
    checkSig("early req grestore@31", {2'b00, grestore_o}, 3'd0);
    checkSig("early req state@31",    state_o,             3'd4);
    applyStimulus(1, 1, 1);
    checkSig("late req grestore", {2'b00, grestore_o}, 3'd1);

    // Asynchronous reset in the middle of a restore.
    applyStimulus(1, 0, 3);
    doReset(2);

    // Randomized phase: occasional lock drops, random request toggling.
    lowLeft = 0;
    reqV    = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (lowLeft > 0) begin
        pllV = 1'b0;
        lowLeft--;
      end else begin
        pllV = 1'b1;
        if ($urandom_range(0, 199) == 0) lowLeft = int'($urandom_range(1, 5));
      end
      if ($urandom_range(0, 9) == 0) reqV = !reqV;
      applyStimulus(pllV, reqV, 1);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
